// File: rtl/load_store_unit_pkg.sv
// Shared constants and FSM encoding for the load/store unit and data memory.
package load_store_unit_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 64;

    // Width of the signed effective-address sum: 8-bit base + sign-extended offset.
    localparam int EA_W      = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_addr_gen.sv
// Effective-address generation and range check for the load/store unit.
module lsu_addr_gen
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = load_store_unit_pkg::ADDR_W
) (
    input  logic [7:0]        base_i,
    input  logic [7:0]        offset_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              fault_o
);

    localparam logic signed [EA_W-1:0] MaxAddr = EA_W'((1 << ADDR_W) - 1);

    logic signed [EA_W-1:0] ea;

    // Zero-extended base plus sign-extended offset, then bounds check against memory size.
    always_comb begin
        ea      = $signed({2'b00, base_i}) + $signed({{2{offset_i[7]}}, offset_i});
        fault_o = (ea < 0) || (ea > MaxAddr);
        addr_o  = fault_o ? '0 : ea[ADDR_W-1:0];
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, performs one memory access, returns one response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = load_store_unit_pkg::ADDR_W,
    parameter int DATA_W = load_store_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [7:0]        req_base,
    input  logic [7:0]        req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    input  logic [DATA_W-1:0] read_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              store_q;
    logic              fault_q;

    logic [ADDR_W-1:0] gen_addr;
    logic              gen_fault;
    logic              accept;

    lsu_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base_i   (req_base),
        .offset_i (req_offset),
        .addr_o   (gen_addr),
        .fault_o  (gen_fault)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture address, data, op type and fault at acceptance; held until the next acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= gen_addr;
            wdata_q <= req_wdata;
            store_q <= req_store;
            fault_q <= gen_fault;
        end
    end

    // Load result sampled at the end of ACCESS; stores and faults return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (!store_q && !fault_q) ? read_data : '0;
        end
    end

    // Write strobe decoded purely from registers so reset drops it asynchronously.
    always_comb begin
        write_enable = (state_q == ACCESS) && store_q && !fault_q;
    end

    assign data_address = addr_q;
    assign write_data   = wdata_q;
    assign resp_rdata   = rdata_q;
    assign resp_fault   = fault_q;

endmodule
